// File: rtl/port_sequencer_pkg.sv
// Shared types and helpers for the host-side port sequencer.
package port_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } seq_state_t;

  // Largest of the three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter is loaded with (phase length - 1), so it must hold max_cyc-1.
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc > 2) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above the pointer, wrapping.
module rr_arbiter
  import port_sequencer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan pointer+1 .. pointer+NREQ (mod NREQ); the first hit wins.
  always_comb begin
    any_req = |req;
    grant   = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_sequencer.sv
// Arbitrates requesters onto the computer's port_in/port_write path and
// turns changes on port_out into one-cycle events.
//
// state   | meaning
// IDLE    | sample req, grant and latch data on any request
// SETUP   | data driven, strobe low (SETUP_CYC cycles)
// STROBE  | data driven, strobe high (HOLD_CYC cycles)
// RELEASE | data held, strobe low; ack in the last cycle (RELEASE_CYC cycles)
module port_sequencer
  import port_sequencer_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int SETUP_CYC   = 1,
  parameter int HOLD_CYC    = 2,
  parameter int RELEASE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic [WIDTH-1:0]         cpu_port_in,
  output logic                     cpu_port_write,
  input  logic [WIDTH-1:0]         cpu_port_out,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = cnt_width(max3(SETUP_CYC, HOLD_CYC, RELEASE_CYC));

  if (NREQ < 2 || SETUP_CYC < 1 || HOLD_CYC < 1 || RELEASE_CYC < 1) begin : g_bad_param
    $error("port_sequencer: NREQ must be >= 2 and every *_CYC must be >= 1");
  end

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] grant_nxt, arb_grant;
  logic [WIDTH-1:0] data_nxt;
  logic [NREQ-1:0]  ack_nxt;
  logic             write_nxt;
  logic             any_req;
  logic [WIDTH-1:0] req_word [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  assign busy = (state != IDLE);

  // Next-state, phase down-counter and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    data_nxt  = cpu_port_in;
    ack_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          grant_nxt = arb_grant;
          ptr_nxt   = arb_grant;
          data_nxt  = req_word[arb_grant];
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = RELEASE;
          cnt_nxt   = CNT_W'(RELEASE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    write_nxt = (state_nxt == STROBE);
    if (state_nxt == RELEASE && cnt_nxt == '0) begin
      ack_nxt[grant_nxt] = 1'b1;
    end
  end

  // Sequencer state and registered transfer outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      ptr            <= IDX_W'(NREQ - 1);
      grant_id       <= '0;
      cpu_port_in    <= '0;
      cpu_port_write <= 1'b0;
      ack            <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ptr            <= ptr_nxt;
      grant_id       <= grant_nxt;
      cpu_port_in    <= data_nxt;
      cpu_port_write <= write_nxt;
      ack            <= ack_nxt;
    end
  end

  // Capture port_out every cycle and flag a changed sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_data  <= cpu_port_out;
      out_valid <= (cpu_port_out != out_data);
    end
  end

endmodule

// File: tb/tb_port_sequencer.sv
// Self-checking bench: a transfer-timeline model checked every cycle against
// two instances (default timing and 2/3/2 timing), plus directed scenarios.
module tb_port_sequencer;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_v  [2];
  logic [63:0] data_v [2];
  logic [15:0] pout;

  logic [3:0]  ack_o  [2];
  logic        busy_o [2];
  logic [1:0]  gid_o  [2];
  logic [15:0] pin_o  [2];
  logic        wr_o   [2];
  logic [15:0] od_o   [2];
  logic        ov_o   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  port_sequencer dut (
    .clk(clk), .reset(reset), .req(req_v[0]), .req_data(data_v[0]),
    .ack(ack_o[0]), .busy(busy_o[0]), .grant_id(gid_o[0]),
    .cpu_port_in(pin_o[0]), .cpu_port_write(wr_o[0]), .cpu_port_out(pout),
    .out_data(od_o[0]), .out_valid(ov_o[0])
  );

  port_sequencer #(.SETUP_CYC(2), .HOLD_CYC(3), .RELEASE_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .req(req_v[1]), .req_data(data_v[1]),
    .ack(ack_o[1]), .busy(busy_o[1]), .grant_id(gid_o[1]),
    .cpu_port_in(pin_o[1]), .cpu_port_write(wr_o[1]), .cpu_port_out(pout),
    .out_data(od_o[1]), .out_valid(ov_o[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one transfer = timeline t=1..S+H+R after grant
  int          s_cyc [2] = '{1, 2};
  int          h_cyc [2] = '{2, 3};
  int          r_cyc [2] = '{1, 2};
  bit          m_act [2];
  int          m_t   [2];
  int          m_g   [2];
  int          m_ptr [2];
  logic [15:0] m_data[2];
  logic [15:0] m_od  [2];
  bit          m_ov  [2];
  bit          started = 1'b0;
  int          m_idx;
  bit          m_found;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] = 1'b0; m_t[k] = 0; m_g[k] = 0; m_ptr[k] = NREQ - 1;
        m_data[k] = '0; m_od[k] = '0; m_ov[k] = 1'b0;
      end else begin
        m_ov[k] = (pout != m_od[k]);
        m_od[k] = pout;
        if (m_act[k]) begin
          m_t[k]++;
          if (m_t[k] > s_cyc[k] + h_cyc[k] + r_cyc[k]) m_act[k] = 1'b0;
        end else if (req_v[k] != 4'b0) begin
          m_found = 1'b0;
          for (int j = 1; j <= NREQ; j++) begin
            m_idx = (m_ptr[k] + j) % NREQ;
            if (!m_found && req_v[k][m_idx]) begin
              m_g[k]  = m_idx;
              m_found = 1'b1;
            end
          end
          m_ptr[k]  = m_g[k];
          m_data[k] = 16'(data_v[k] >> (m_g[k] * WIDTH));
          m_act[k]  = 1'b1;
          m_t[k]    = 1;
        end
      end
    end
    if (reset) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic       e_wr;
        logic [3:0] e_ack;
        e_wr  = m_act[k] && m_t[k] > s_cyc[k] && m_t[k] <= s_cyc[k] + h_cyc[k];
        e_ack = (m_act[k] && m_t[k] == s_cyc[k] + h_cyc[k] + r_cyc[k]) ? (4'b0001 << m_g[k]) : 4'b0000;
        check($sformatf("busy[%0d]", k),  busy_o[k], m_act[k]);
        check($sformatf("write[%0d]", k), wr_o[k], e_wr);
        check($sformatf("ack[%0d]", k),   ack_o[k], e_ack);
        check($sformatf("grant[%0d]", k), gid_o[k], m_g[k]);
        check($sformatf("port_in[%0d]", k), pin_o[k], m_data[k]);
        check($sformatf("out_data[%0d]", k), od_o[k], m_od[k]);
        check($sformatf("out_valid[%0d]", k), ov_o[k], m_ov[k]);
      end
    end
  end

  // ---------------- directed scenarios
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_v[0] = '0;
    req_v[1] = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          order[4];
    logic [15:0] strobes[4];
    int          n_ack, n_str, n_pulse, p1, p2, first_wr, wr_cnt, ack_cyc, busy_cnt;
    logic        prev_wr;
    logic [3:0]  last_ack;
    logic [15:0] pvals[8];

    req_v[0] = '0; req_v[1] = '0; data_v[0] = '0; data_v[1] = '0; pout = '0;

    // Test 1: single request, default timing, plus reset values.
    do_reset();
    data_v[0][15:0] = 16'h1234;
    req_v[0] = 4'b0001;
    check("t1 reset busy", busy_o[0], 1'b0);
    check("t1 reset ack", ack_o[0], 4'b0);
    check("t1 reset grant", gid_o[0], 2'd0);
    check("t1 reset port_in", pin_o[0], 16'h0);
    check("t1 reset write", wr_o[0], 1'b0);
    check("t1 reset out_data", od_o[0], 16'h0);
    check("t1 reset out_valid", ov_o[0], 1'b0);
    step();
    check("t1 c1 port_in", pin_o[0], 16'h1234);
    check("t1 c1 write", wr_o[0], 1'b0);
    step();
    check("t1 c2 write", wr_o[0], 1'b1);
    step();
    check("t1 c3 write", wr_o[0], 1'b1);
    step();
    check("t1 c4 ack", ack_o[0], 4'b0001);
    check("t1 c4 write", wr_o[0], 1'b0);
    step();
    req_v[0] = 4'b0;
    check("t1 c5 busy", busy_o[0], 1'b0);

    // Test 2: all four requesting; rotation 0..3 in 20 cycles.
    do_reset();
    data_v[0] = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    req_v[0] = 4'hF;
    last_ack = '0; n_ack = 0; n_str = 0; prev_wr = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      req_v[0] = req_v[0] & ~last_ack;
      last_ack = ack_o[0];
      if (ack_o[0] != 4'b0 && n_ack < 4) begin
        order[n_ack] = gid_o[0];
        n_ack++;
      end
      if (wr_o[0] && !prev_wr && n_str < 4) begin
        strobes[n_str] = pin_o[0];
        n_str++;
      end
      prev_wr = wr_o[0];
    end
    check("t2 ack count", n_ack, 4);
    check("t2 strobe count", n_str, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2 grant order %0d", i), order[i], i);
      check($sformatf("t2 strobe data %0d", i), strobes[i], 16'hA000 + 16'(i));
    end
    req_v[0] = '0;

    // Test 3: reset during STROBE of requester 2.
    do_reset();
    data_v[0] = {16'h3333, 16'hC0DE, 16'h1111, 16'h0F0F};
    req_v[0] = 4'b0100;
    step();
    step();
    check("t3 c2 write", wr_o[0], 1'b1);
    check("t3 c2 grant", gid_o[0], 2'd2);
    reset = 1'b1;
    step();
    check("t3 abort write", wr_o[0], 1'b0);
    check("t3 abort port_in", pin_o[0], 16'h0);
    check("t3 abort ack", ack_o[0], 4'b0);
    reset = 1'b0;
    req_v[0] = 4'b0101;
    step();
    check("t3 regrant id", gid_o[0], 2'd0);
    check("t3 regrant data", pin_o[0], 16'h0F0F);
    step(); step(); step();
    check("t3 regrant ack", ack_o[0], 4'b0001);
    req_v[0] = '0;
    step();

    // Test 4: port_out change detection.
    do_reset();
    pvals = '{16'h0000, 16'h00FF, 16'h00FF, 16'h00FF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    n_pulse = 0; p1 = -1; p2 = -1;
    for (int c = 0; c < 8; c++) begin
      pout = pvals[c];
      step();
      check($sformatf("t4 out_data c%0d", c + 1), od_o[0], pvals[c]);
      if (ov_o[0]) begin
        n_pulse++;
        if (p1 < 0) p1 = c + 1; else p2 = c + 1;
      end
    end
    check("t4 pulse count", n_pulse, 2);
    check("t4 first pulse cycle", p1, 2);
    check("t4 second pulse cycle", p2, 5);
    pout = '0;

    // Test 5: req and data withdrawn during SETUP.
    do_reset();
    data_v[0] = '0;
    data_v[0][31:16] = 16'h5555;
    req_v[0] = 4'b0010;
    step();
    check("t5 c1 write", wr_o[0], 1'b0);
    req_v[0] = '0;
    data_v[0][31:16] = 16'h0000;
    step();
    check("t5 c2 write", wr_o[0], 1'b1);
    check("t5 c2 data", pin_o[0], 16'h5555);
    step();
    check("t5 c3 data", pin_o[0], 16'h5555);
    step();
    check("t5 c4 ack", ack_o[0], 4'b0010);
    step();

    // Test 6: SETUP=2, HOLD=3, RELEASE=2 instance.
    do_reset();
    data_v[1][15:0] = 16'h7777;
    req_v[1] = 4'b0001;
    first_wr = -1; wr_cnt = 0; ack_cyc = -1; busy_cnt = 0; last_ack = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      req_v[1] = req_v[1] & ~last_ack;
      last_ack = ack_o[1];
      if (wr_o[1]) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = c;
      end
      if (ack_o[1] != 4'b0) ack_cyc = c;
      if (busy_o[1]) busy_cnt++;
    end
    check("t6 first strobe cycle", first_wr, 3);
    check("t6 strobe width", wr_cnt, 3);
    check("t6 ack cycle", ack_cyc, 7);
    check("t6 busy cycles", busy_cnt, 7);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
